// File: rtl/card_pkg.sv
// ---------------------------------------------------------------------------
// card_pkg
// Shared types and constants for the card-corner suit recognizer. Used by the
// per-suit XOR matchers, the suit classifier and the card-identification
// logic.
//   suit_t           : suit code (0 club, 1 diamond, 2 heart, 3 spade)
//   SUIT_COUNT       : number of suits scored per card corner
//   SUIT_SCORE_WIDTH : width of one mismatch score ($clog2(28*29) = 10)
//   cls_state_t      : suit classifier FSM state, exported for debug
// ---------------------------------------------------------------------------
package card_pkg;

    typedef enum logic [1:0] {
        CLUB    = 2'd0,
        DIAMOND = 2'd1,
        HEART   = 2'd2,
        SPADE   = 2'd3
    } suit_t;

    localparam int SUIT_COUNT       = 4;
    localparam int SUIT_SCORE_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_OUTPUT  = 2'd3
    } cls_state_t;

endpackage

// File: rtl/suit_classifier_if.sv
// ---------------------------------------------------------------------------
// suit_classifier_if
// Bundles the score inputs and the classification result handshake of
// suit_classifier.
//   score_in[4]   : mismatch scores, index = suit code
//   score_valid   : one-cycle strobe per suit, score sampled when high
//   result_valid  : result available
//   result_ready  : downstream accepts result
//   result_suit   : winning suit code
//   best_score    : lowest score
//   second_score  : runner-up score
//   match         : confident classification
//   timed_out     : result forced by the collect timeout
// Handshake: a result transfers on the rising clk edge where result_valid and
// result_ready are both high. Once result_valid rises it stays high, with all
// result fields stable, until that transfer (only rst may drop it earlier);
// result_ready may be driven freely and never gates result_valid.
// Modports: master = score producers / result consumer, slave = classifier.
// ---------------------------------------------------------------------------
interface suit_classifier_if #(
    parameter int SCORE_WIDTH = card_pkg::SUIT_SCORE_WIDTH
);
    import card_pkg::*;

    logic [SCORE_WIDTH-1:0] score_in [SUIT_COUNT];
    logic [SUIT_COUNT-1:0]  score_valid;
    logic                   result_valid;
    logic                   result_ready;
    suit_t                  result_suit;
    logic [SCORE_WIDTH-1:0] best_score;
    logic [SCORE_WIDTH-1:0] second_score;
    logic                   match;
    logic                   timed_out;

    modport master (
        output score_in, score_valid, result_ready,
        input  result_valid, result_suit, best_score, second_score, match,
               timed_out
    );

    modport slave (
        input  score_in, score_valid, result_ready,
        output result_valid, result_suit, best_score, second_score, match,
               timed_out
    );

endinterface

// File: rtl/suit_classifier.sv
// ---------------------------------------------------------------------------
// suit_classifier
// Final decision stage of the suit recognizer. Captures the four per-suit
// mismatch scores, scans them one per cycle to find the lowest and runner-up
// scores, judges confidence (absolute threshold + runner-up margin) and
// presents one result per card corner over a valid/ready handshake.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   bus       : suit_classifier_if.slave (scores in, result handshake out)
//   dbg_state : current FSM state
// Parameters: SCORE_WIDTH, THRESHOLD, MARGIN, TIMEOUT.
// Optional feature macro SUIT_CLASSIFIER_TIMEOUT_EN: when defined, a partly
// collected score set is forced into classification TIMEOUT cycles after its
// first score, missing suits reading as all-ones, and timed_out is raised for
// that result. Otherwise collection waits for all four suits and timed_out
// is constant 0.
// ---------------------------------------------------------------------------
module suit_classifier
    import card_pkg::*;
#(
    parameter int SCORE_WIDTH = SUIT_SCORE_WIDTH,
    parameter int THRESHOLD   = 200,
    parameter int MARGIN      = 40,
    parameter int TIMEOUT     = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    suit_classifier_if.slave         bus,
    output cls_state_t               dbg_state
);

    localparam logic [SCORE_WIDTH-1:0] ALL_ONES = '1;

    // FSM and capture registers
    cls_state_t             state_q, state_d;
    logic [SCORE_WIDTH-1:0] score_q   [SUIT_COUNT];
    logic [SCORE_WIDTH-1:0] score_d   [SUIT_COUNT];
    logic [SUIT_COUNT-1:0]  present_q, present_d;
    logic [1:0]             idx_q, idx_d;

    // Running minimum / runner-up during COMPARE
    logic [SCORE_WIDTH-1:0] best_q, best_d;
    logic [SCORE_WIDTH-1:0] second_q, second_d;
    suit_t                  best_suit_q, best_suit_d;

    // Result registers, held stable while OUTPUT waits for acceptance
    suit_t                  res_suit_q, res_suit_d;
    logic [SCORE_WIDTH-1:0] res_best_q, res_best_d;
    logic [SCORE_WIDTH-1:0] res_second_q, res_second_d;
    logic                   match_q, match_d;

`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   to_pend_q, to_pend_d;
    logic                   timed_out_q, timed_out_d;
`endif

    // Comparator step for the suit selected by idx_q
    logic [SCORE_WIDTH-1:0] cur_score;
    logic [SCORE_WIDTH-1:0] cand_best;
    logic [SCORE_WIDTH-1:0] cand_second;
    suit_t                  cand_suit;
    logic                   cand_match;

    always_comb begin
        cur_score   = present_q[idx_q] ? score_q[idx_q] : ALL_ONES;
        cand_best   = best_q;
        cand_second = second_q;
        cand_suit   = best_suit_q;
        if (idx_q == 2'd0) begin
            // First suit seeds the scan; runner-up starts at all-ones.
            cand_best   = cur_score;
            cand_second = ALL_ONES;
            cand_suit   = CLUB;
        end else if (cur_score < best_q) begin
            // Strict less-than: on a tie the lower suit code keeps the win.
            cand_best   = cur_score;
            cand_second = best_q;
            cand_suit   = suit_t'(idx_q);
        end else if (cur_score < second_q) begin
            cand_second = cur_score;
        end
        // cand_second >= cand_best always holds, so the unsigned difference
        // is the true margin.
        cand_match = (cand_best <= SCORE_WIDTH'(THRESHOLD)) &&
                     ((cand_second - cand_best) >= SCORE_WIDTH'(MARGIN));
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        present_d    = present_q;
        idx_d        = idx_q;
        best_d       = best_q;
        second_d     = second_q;
        best_suit_d  = best_suit_q;
        res_suit_d   = res_suit_q;
        res_best_d   = res_best_q;
        res_second_d = res_second_q;
        match_d      = match_q;
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
        cnt_d        = cnt_q;
        to_pend_d    = to_pend_q;
        timed_out_d  = timed_out_q;
`endif

        // Scores are only taken while collecting; later strobes are dropped.
        if (state_q == ST_IDLE || state_q == ST_COLLECT) begin
            for (int i = 0; i < SUIT_COUNT; i++) begin
                if (bus.score_valid[i]) begin
                    score_d[i] = bus.score_in[i];
                end
            end
            present_d = present_q | bus.score_valid;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.score_valid != '0) begin
                    idx_d = 2'd0;
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
                    cnt_d     = '0;
                    to_pend_d = 1'b0;
`endif
                    state_d = (&present_d) ? ST_COMPARE : ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (&present_d) begin
                    idx_d   = 2'd0;
                    state_d = ST_COMPARE;
                end
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    idx_d     = 2'd0;
                    to_pend_d = 1'b1;
                    state_d   = ST_COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_COMPARE: begin
                best_d      = cand_best;
                second_d    = cand_second;
                best_suit_d = cand_suit;
                idx_d       = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    res_suit_d   = cand_suit;
                    res_best_d   = cand_best;
                    res_second_d = cand_second;
                    match_d      = cand_match;
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
                    timed_out_d  = to_pend_q;
`endif
                    state_d      = ST_OUTPUT;
                end
            end

            ST_OUTPUT: begin
                if (bus.result_ready) begin
                    present_d = '0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < SUIT_COUNT; i++) begin
                score_q[i] <= '0;
            end
            present_q    <= '0;
            idx_q        <= 2'd0;
            best_q       <= '0;
            second_q     <= '0;
            best_suit_q  <= CLUB;
            res_suit_q   <= CLUB;
            res_best_q   <= '0;
            res_second_q <= '0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            present_q    <= present_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            second_q     <= second_d;
            best_suit_q  <= best_suit_d;
            res_suit_q   <= res_suit_d;
            res_best_q   <= res_best_d;
            res_second_q <= res_second_d;
            match_q      <= match_d;
        end
    end

`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            to_pend_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            to_pend_q   <= to_pend_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign bus.timed_out = timed_out_q;
`else
    assign bus.timed_out = 1'b0;
`endif

    assign bus.result_valid = (state_q == ST_OUTPUT);
    assign bus.result_suit  = res_suit_q;
    assign bus.best_score   = res_best_q;
    assign bus.second_score = res_second_q;
    assign bus.match        = match_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_suit_classifier.sv
// ---------------------------------------------------------------------------
// tb_suit_classifier
// Directed and randomized checks of suit_classifier against a transaction
// level reference model (argmin / second-smallest over the captured scores).
// Define SUIT_CLASSIFIER_TIMEOUT_EN to build the timeout variant (TIMEOUT=64).
// ---------------------------------------------------------------------------
module tb_suit_classifier;
    import card_pkg::*;

    localparam int W       = 10;
    localparam int MAXV    = 1023;
    localparam int THR     = 200;
    localparam int MRG     = 40;
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 64;
`else
    localparam int TB_TIMEOUT = 4096;
`endif

    logic       clk;
    logic       rst;
    cls_state_t dbg_state;

    suit_classifier_if #(.SCORE_WIDTH(W)) sc_bus ();

    suit_classifier #(
        .SCORE_WIDTH (W),
        .THRESHOLD   (THR),
        .MARGIN      (MRG),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (sc_bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int          cyc;
    bit          m_hold;
    int          m_ready_at;
    bit [3:0]    m_pres;
    logic [W-1:0] m_sc [4];
    int          m_start;
    int          e_suit, e_best, e_second;
    bit          e_match, e_to;
    int          n_acc;

    function automatic void m_compute(bit to);
        int v [4];
        for (int i = 0; i < 4; i++) v[i] = m_pres[i] ? int'(m_sc[i]) : MAXV;
        e_suit = 0;
        for (int i = 1; i < 4; i++) if (v[i] < v[e_suit]) e_suit = i;
        e_best   = v[e_suit];
        e_second = MAXV;
        for (int i = 0; i < 4; i++) if (i != e_suit && v[i] < e_second) e_second = v[i];
        e_match = (e_best <= THR) && (e_second - e_best >= MRG);
        e_to    = to;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc        = 0;
            m_hold     = 1'b0;
            m_ready_at = -1;
            m_pres     = '0;
        end else begin
            cyc++;
            if (m_hold) begin
                if (sc_bus.result_ready) begin
                    m_hold = 1'b0;
                    m_pres = '0;
                    n_acc++;
                end
            end else if (m_ready_at >= 0) begin
                if (m_ready_at == cyc + 1) begin
                    m_hold     = 1'b1;
                    m_ready_at = -1;
                end
            end else begin
                if (m_pres == 0 && sc_bus.score_valid != 0) m_start = cyc;
                for (int i = 0; i < 4; i++) begin
                    if (sc_bus.score_valid[i]) begin
                        m_sc[i]   = sc_bus.score_in[i];
                        m_pres[i] = 1'b1;
                    end
                end
                if (&m_pres) begin
                    m_compute(1'b0);
                    m_ready_at = cyc + 5;
                end
`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
                else if (m_pres != 0 && cyc == m_start + TB_TIMEOUT) begin
                    m_compute(1'b1);
                    m_ready_at = cyc + 5;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("cyc_valid", int'(sc_bus.result_valid), int'(m_hold));
            if (m_hold) begin
                chk("cyc_suit",   int'(sc_bus.result_suit),  e_suit);
                chk("cyc_best",   int'(sc_bus.best_score),   e_best);
                chk("cyc_second", int'(sc_bus.second_score), e_second);
                chk("cyc_match",  int'(sc_bus.match),        int'(e_match));
                chk("cyc_to",     int'(sc_bus.timed_out),    int'(e_to));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input bit [3:0] mask, input int s0, input int s1,
                          input int s2, input int s3);
        @(negedge clk);
        sc_bus.score_in[0] = W'(s0);
        sc_bus.score_in[1] = W'(s1);
        sc_bus.score_in[2] = W'(s2);
        sc_bus.score_in[3] = W'(s3);
        sc_bus.score_valid = mask;
        @(negedge clk);
        sc_bus.score_valid = '0;
    endtask

    task automatic wait_valid(input string nm, input int budget, output int waited);
        waited = 0;
        while (!sc_bus.result_valid) begin
            if (waited >= budget) begin
                chk({nm, "_wait_timeout"}, 0, 1);
                return;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic check_result(input string nm, input int suit, input int best,
                                input int second, input int mt, input int to);
        chk({nm, "_valid"},  int'(sc_bus.result_valid), 1);
        chk({nm, "_suit"},   int'(sc_bus.result_suit),  suit);
        chk({nm, "_best"},   int'(sc_bus.best_score),   best);
        chk({nm, "_second"}, int'(sc_bus.second_score), second);
        chk({nm, "_match"},  int'(sc_bus.match),        mt);
        chk({nm, "_to"},     int'(sc_bus.timed_out),    to);
    endtask

    task automatic accept(input string nm);
        sc_bus.result_ready = 1'b1;
        @(negedge clk);
        sc_bus.result_ready = 1'b0;
        chk({nm, "_dropped_after_accept"}, int'(sc_bus.result_valid), 0);
    endtask

    // ---------------- main sequence ----------------
    int w;

    initial begin
        n_acc = 0;
        rst = 1'b1;
        sc_bus.score_valid  = '0;
        sc_bus.result_ready = 1'b0;
        for (int i = 0; i < 4; i++) sc_bus.score_in[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  int'(sc_bus.result_valid), 0);
        chk("rst_suit",   int'(sc_bus.result_suit),  0);
        chk("rst_best",   int'(sc_bus.best_score),   0);
        chk("rst_second", int'(sc_bus.second_score), 0);
        chk("rst_match",  int'(sc_bus.match),        0);
        chk("rst_to",     int'(sc_bus.timed_out),    0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Simultaneous strobes: result 5 cycles after the sampling cycle.
        strobe(4'hF, 300, 50, 400, 500);
        wait_valid("t1", 20, w);
        chk("t1_latency", w, 4);
        check_result("t1", 1, 50, 300, 1, 0);
        accept("t1");

        // Staggered strobes, tie goes to the lower suit code.
        for (int i = 0; i < 4; i++) begin
            strobe(4'(1 << i), 100, 600, 700, 100);
            if (i < 3) repeat (19) @(negedge clk);
        end
        wait_valid("t2", 20, w);
        chk("t2_latency", w, 4);
        check_result("t2", 0, 100, 100, 0, 0);
        accept("t2");

        // Best above threshold.
        strobe(4'hF, 250, 900, 900, 900);
        wait_valid("t3", 20, w);
        check_result("t3", 0, 250, 900, 0, 0);
        accept("t3");

        // Margin exactly 40 while ready held low, strobes injected meanwhile.
        strobe(4'hF, 120, 700, 80, 650);
        wait_valid("t4", 20, w);
        check_result("t4", 2, 80, 120, 1, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_result("t4_hold", 2, 80, 120, 1, 0);
            for (int i = 0; i < 4; i++) sc_bus.score_in[i] = W'(5);
            sc_bus.score_valid = (k % 3 == 0) ? 4'hF : 4'h0;
        end
        @(negedge clk);
        sc_bus.score_valid = '0;
        accept("t4");
        // Best exactly at threshold, margin exactly 40.
        strobe(4'hF, 400, 401, 200, 240);
        wait_valid("t5", 20, w);
        chk("t5_latency", w, 4);
        check_result("t5", 2, 200, 240, 1, 0);
        accept("t5");

        // Threshold + 1, then margin 39.
        strobe(4'hF, 201, 500, 500, 500);
        wait_valid("t6", 20, w);
        check_result("t6", 0, 201, 500, 0, 0);
        accept("t6");
        strobe(4'hF, 139, 100, 600, 600);
        wait_valid("t7", 20, w);
        check_result("t7", 1, 100, 139, 0, 0);
        accept("t7");

        // Asynchronous reset in the middle of COMPARE.
        strobe(4'hF, 800, 10, 800, 800);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid",  int'(sc_bus.result_valid), 0);
        chk("mid_rst_suit",   int'(sc_bus.result_suit),  0);
        chk("mid_rst_best",   int'(sc_bus.best_score),   0);
        chk("mid_rst_second", int'(sc_bus.second_score), 0);
        chk("mid_rst_match",  int'(sc_bus.match),        0);
        @(negedge clk);
        rst = 1'b0;
        strobe(4'hF, 800, 10, 800, 800);
        wait_valid("t8", 20, w);
        check_result("t8", 1, 10, 800, 1, 0);
        accept("t8");

`ifdef SUIT_CLASSIFIER_TIMEOUT_EN
        // Only heart arrives: forced classification after the timeout.
        strobe(4'b0100, 0, 0, 30, 0);
        wait_valid("t9", 200, w);
        chk("t9_latency", w, TB_TIMEOUT + 4);
        check_result("t9", 2, 30, MAXV, 1, 1);
        accept("t9");
`endif

        // Randomized traffic checked cycle by cycle against the model.
        n_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sc_bus.result_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                sc_bus.score_in[i] = ($urandom_range(0, 1) == 1) ?
                    W'($urandom_range(0, MAXV)) : W'($urandom_range(150, 260));
                sc_bus.score_valid[i] = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        sc_bus.score_valid  = '0;
        sc_bus.result_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("rand_results_seen", int'(n_acc > 20), 1);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
